// File: rtl/tff_array.sv
// tff_array: WIDTH-bit T flip-flop array with toggle, chained-T up/down count, load, terminal-count and change flags.
// Ports: clk, i_rst (sync active-high), i_en, i_mode (00 TOGGLE, 01 UP, 10 DOWN, 11 LOAD), i_t (toggle/load data),
//        o_q (state), o_qbar (~o_q), o_tc (limit-hit pulse), o_chg (o_q changed at last edge).
module tff_array #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter bit               WRAP    = 1'b1
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_t,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_qbar,
  output logic             o_tc,
  output logic             o_chg
);
  localparam logic [1:0] M_TOG = 2'b00, M_UP = 2'b01, M_DN = 2'b10, M_LD = 2'b11;
  logic [WIDTH-1:0] q = RST_VAL;
  logic tc = 1'b0;
  logic chg = 1'b0;
  logic [WIDTH-1:0] up_t, dn_t, tmask;
  logic ca, cd, at_lim;
  // Every mode is expressed as a per-bit toggle mask; o_chg is simply "any bit toggled".
  always_comb begin
    ca = 1'b1;
    cd = 1'b1;
    for (int k = 0; k < WIDTH; k++) begin
      up_t[k] = ca;
      dn_t[k] = cd;
      ca = ca & q[k];
      cd = cd & ~q[k];
    end
    at_lim = (i_mode == M_UP && &q) || (i_mode == M_DN && ~|q);
    tmask = i_mode == M_TOG ? i_t :
            i_mode == M_LD  ? q ^ i_t :
            (at_lim && !WRAP) ? '0 :
            i_mode == M_UP  ? up_t : dn_t;
  end
  always_ff @(posedge clk) begin
    if (i_rst) begin
      q   <= RST_VAL;
      tc  <= 1'b0;
      chg <= 1'b0;
    end else if (i_en) begin
      q   <= q ^ tmask;
      tc  <= at_lim;
      chg <= |tmask;
    end else begin
      tc  <= 1'b0;
      chg <= 1'b0;
    end
  end
  assign o_q    = q;
  assign o_qbar = ~q;
  assign o_tc   = tc;
  assign o_chg  = chg;
endmodule

// File: tb/tb_tff_array.sv
// tb_tff_array: randomized and directed self-checking bench for tff_array with three parameterisations.
module tb_tff_array;
  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] ti = 4'h0;
  logic [3:0] q0, q1, q2, qb0, qb1, qb2;
  logic tc0, tc1, tc2, ch0, ch1, ch2;
  int compared = 0, mismatched = 0;
  logic [3:0] mq[3];
  bit mtc[3], mchg[3];
  bit wr[3] = '{1'b1, 1'b0, 1'b1};
  logic [3:0] rv[3] = '{4'h0, 4'h0, 4'hA};

  always #5 clk = ~clk;

  tff_array #(.WIDTH(4), .RST_VAL(4'h0), .WRAP(1'b1)) u_a (.clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_t(ti),
    .o_q(q0), .o_qbar(qb0), .o_tc(tc0), .o_chg(ch0));
  tff_array #(.WIDTH(4), .RST_VAL(4'h0), .WRAP(1'b0)) u_b (.clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_t(ti),
    .o_q(q1), .o_qbar(qb1), .o_tc(tc1), .o_chg(ch1));
  tff_array #(.WIDTH(4), .RST_VAL(4'hA), .WRAP(1'b1)) u_c (.clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_t(ti),
    .o_q(q2), .o_qbar(qb2), .o_tc(tc2), .o_chg(ch2));

  task automatic step(input bit r, input bit e, input logic [1:0] m, input logic [3:0] t);
    int v, nv;
    bit lim;
    rst = r; en = e; mode = m; ti = t;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      v = int'(mq[k]);
      if (r) begin
        mq[k] = rv[k]; mtc[k] = 0; mchg[k] = 0;
      end else if (!e) begin
        mtc[k] = 0; mchg[k] = 0;
      end else begin
        lim = 0;
        case (m)
          2'b00: nv = v ^ int'(t);
          2'b01: if (v == 15) begin lim = 1; nv = wr[k] ? 0 : v; end else nv = v + 1;
          2'b10: if (v == 0) begin lim = 1; nv = wr[k] ? 15 : v; end else nv = v - 1;
          default: nv = int'(t);
        endcase
        mtc[k] = lim; mchg[k] = (nv != v); mq[k] = 4'(nv);
      end
    end
  endtask

  task automatic test_reset;
    #1;
    compared++;
    if (q2 !== 4'hA || qb2 !== 4'h5) begin mismatched++; $display("FAIL powerup q=%h qbar=%h exp q=a qbar=5", q2, qb2); end
    step(1, 1, 2'b01, 4'hF);
    compared++;
    if ({q0, q1, q2} !== 12'h00A || {tc0, tc1, tc2, ch0, ch1, ch2} !== 6'b0) begin
      mismatched++; $display("FAIL reset q=%h/%h/%h tc/chg=%b%b%b%b%b%b exp 0/0/a all 0", q0, q1, q2, tc0, tc1, tc2, ch0, ch1, ch2);
    end
    compared++;
    if ({qb0, qb1, qb2} !== 12'hFF5) begin mismatched++; $display("FAIL reset_qbar %h/%h/%h exp f/f/5", qb0, qb1, qb2); end
  endtask

  task automatic test_toggle;
    logic [3:0] eq[2] = '{4'h5, 4'h0};
    logic [3:0] eb[2] = '{4'hA, 4'hF};
    step(1, 0, 2'b00, 4'h0);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 2'b00, 4'b0101);
      compared++;
      if (q0 !== eq[i] || qb0 !== eb[i] || ch0 !== 1'b1 || tc0 !== 1'b0) begin
        mismatched++; $display("FAIL toggle%0d q=%h qbar=%h chg=%b tc=%b exp %h %h 1 0", i, q0, qb0, ch0, tc0, eq[i], eb[i]);
      end
    end
  endtask

  task automatic test_up_wrap;
    logic [3:0] eq[3] = '{4'hF, 4'h0, 4'h1};
    bit et[3] = '{1'b0, 1'b1, 1'b0};
    step(0, 1, 2'b11, 4'hE);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 2'b01, 4'h0);
      compared++;
      if (q0 !== eq[i] || tc0 !== et[i] || ch0 !== 1'b1) begin
        mismatched++; $display("FAIL up_wrap%0d q=%h tc=%b chg=%b exp %h %b 1", i, q0, tc0, ch0, eq[i], et[i]);
      end
    end
  endtask

  task automatic test_down_sat;
    bit et[3] = '{1'b0, 1'b1, 1'b1};
    bit ec[3] = '{1'b1, 1'b0, 1'b0};
    step(0, 1, 2'b11, 4'h1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 2'b10, 4'hF);
      compared++;
      if (q1 !== 4'h0 || tc1 !== et[i] || ch1 !== ec[i]) begin
        mismatched++; $display("FAIL down_sat%0d q=%h tc=%b chg=%b exp 0 %b %b", i, q1, tc1, ch1, et[i], ec[i]);
      end
    end
  endtask

  task automatic test_enable_hold;
    step(0, 1, 2'b11, 4'h7);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 2'b01, 4'h0);
      compared++;
      if (q0 !== 4'h7 || tc0 !== 1'b0 || ch0 !== 1'b0) begin
        mismatched++; $display("FAIL en_hold%0d q=%h tc=%b chg=%b exp 7 0 0", i, q0, tc0, ch0);
      end
    end
  endtask

  task automatic test_reset_priority;
    step(0, 1, 2'b11, 4'hF);
    step(1, 1, 2'b01, 4'h0);
    compared++;
    if (q2 !== 4'hA || tc2 !== 1'b0 || ch2 !== 1'b0) begin
      mismatched++; $display("FAIL rst_prio q=%h tc=%b chg=%b exp a 0 0", q2, tc2, ch2);
    end
    step(0, 1, 2'b01, 4'h0);
    compared++;
    if (q2 !== 4'hB || tc2 !== 1'b0) begin mismatched++; $display("FAIL rst_next q=%h tc=%b exp b 0", q2, tc2); end
  endtask

  task automatic test_mode_switch;
    logic [1:0] ms[3] = '{2'b01, 2'b10, 2'b11};
    logic [3:0] eq[3] = '{4'h6, 4'h5, 4'h3};
    step(0, 1, 2'b11, 4'h5);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, ms[i], 4'h3);
      compared++;
      if (q0 !== eq[i]) begin mismatched++; $display("FAIL mode_sw%0d q=%h exp %h", i, q0, eq[i]); end
    end
  endtask

  task automatic test_random;
    step(1, 0, 2'b00, 4'h0);
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 29) == 0, $urandom_range(0, 5) != 0, 2'($urandom), 4'($urandom));
      compared++;
      if ({q0, q1, q2} !== {mq[0], mq[1], mq[2]} || {qb0, qb1, qb2} !== ~{mq[0], mq[1], mq[2]} ||
          {tc0, tc1, tc2} !== {mtc[0], mtc[1], mtc[2]} || {ch0, ch1, ch2} !== {mchg[0], mchg[1], mchg[2]}) begin
        mismatched++;
        $display("FAIL rand%0d q=%h/%h/%h tc=%b%b%b chg=%b%b%b exp q=%h/%h/%h tc=%b%b%b chg=%b%b%b", i, q0, q1, q2,
                 tc0, tc1, tc2, ch0, ch1, ch2, mq[0], mq[1], mq[2], mtc[0], mtc[1], mtc[2], mchg[0], mchg[1], mchg[2]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_up_wrap();
    test_down_sat();
    test_enable_hold();
    test_reset_priority();
    test_mode_switch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
